mvb_item_packer: RTL and testbench
==================================

Name: mvb_item_packer

Overview:
- Transmit-side packer for the MVB bus. Accepts a single-item stream (one item per cycle, valid/ready handshake) and packs the items into MVB words of ITEMS lanes, then drives them onto an MVB TX bus.
- Sits in front of any MVB consumer whose producer emits one item at a time, e.g. a parser or DMA header extractor.
- A word is sent when it is full, on an explicit flush, or (optionally) after an idle timeout.

Parameters:
- ITEMS, 4, number of MVB lanes per output word; must be >= 1.
- ITEM_WIDTH, 8, bits per item; must be >= 1.
- TIMEOUT, 16, idle cycles before a partial word is force-sent; only used with MVB_ITEM_PACKER_TIMEOUT_EN; must be >= 1.

Ports:
- CLK  in  1  clock, all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- RX_DATA  in  ITEM_WIDTH  input item.
- RX_SRC_RDY  in  1  input item valid.
- RX_DST_RDY  out  1  packer can accept an item.
- FLUSH  in  1  single-cycle request to send the current partial word.
- TX_DATA  out  ITEMS*ITEM_WIDTH  MVB data; lane i = bits [(i+1)*ITEM_WIDTH-1 : i*ITEM_WIDTH].
- TX_VLD  out  ITEMS  per-lane valid.
- TX_SRC_RDY  out  1  MVB word valid.
- TX_DST_RDY  in  1  MVB consumer ready.

Behaviour:
- Internal state:
  - accumulation register (ITEMS lanes);
  - fill counter cnt, range 0..ITEMS, width clog2(ITEMS+1);
  - FSM with states FILL and SEND.
- Reset (RESET=1 at a clock edge): state=FILL, cnt=0, all lanes zero. Registered outputs TX_DATA=0, TX_VLD=0, TX_SRC_RDY=0. RX_DST_RDY=0 while RESET is high.
- Item transfer: RX_SRC_RDY && RX_DST_RDY. Input is ignored when RX_SRC_RDY=0. RX_DATA is don't-care when not transferred.
- Transfer on the TX side: TX_SRC_RDY && TX_DST_RDY. While TX_SRC_RDY=1 with no transfer, TX_DATA and TX_VLD stay stable.
- FILL state:
  - RX_DST_RDY=1, TX_SRC_RDY=0.
  - An accepted item is written to lane cnt, and cnt is incremented.
  - If the accepted item fills lane ITEMS-1, the next state is SEND with TX_VLD all ones. Latency from accepting the last item to TX_SRC_RDY is 1 cycle.
  - If FLUSH=1 and (cnt>0 or an item is accepted in the same cycle), the next state is SEND with TX_VLD = low (cnt_after_accept) bits set.
  - The same-cycle item is included in the flushed word: store first, then flush.
  - FLUSH with cnt=0 and no accepted item is ignored.
- SEND state:
  - TX_SRC_RDY=1; TX_DATA and TX_VLD are held. Lanes at and above the fill count are zero.
  - RX_DST_RDY = TX_DST_RDY (combinational passthrough).
  - On TX transfer: lanes are cleared. If an item is accepted in the same cycle, it is written to lane 0, cnt=1, and the next state is FILL. Otherwise cnt=0 and the next state is FILL.
  - With ITEMS=1, a same-cycle accept gives cnt=1=ITEMS, and the state stays SEND with the new word.
  - FLUSH is ignored in SEND. FLUSH in the same cycle as a TX transfer with an accept is also ignored; the new item waits in the new word.
  - No TX transfer: state is held, no item is accepted.
- TX_VLD is always contiguous from lane 0. TX_SRC_RDY=1 implies TX_VLD != 0.
- RESET mid-operation: partial or pending words are discarded without being sent. The first cycle after reset is FILL with cnt=0.
- Throughput: 1 item/cycle sustained when TX_DST_RDY=1. No bubble at word boundaries for ITEMS>=2.

Optional Feature:
- Macro: MVB_ITEM_PACKER_TIMEOUT_EN.
- Enabled:
  - An idle counter runs in FILL while cnt>0. It is cleared on any accepted item, in SEND, and on reset.
  - When the idle counter reaches TIMEOUT-1 and no item is accepted that cycle, the next state is SEND with the partial word.
  - A partial word is therefore sent at most TIMEOUT+1 cycles after the last accepted item.
- Disabled: no idle counter is built, TIMEOUT is unused, and partial words leave only on FLUSH or when full.

Test Plan (ITEMS=4, ITEM_WIDTH=8, TIMEOUT=16):
- Full word: items 0x11,0x22,0x33,0x44 on 4 consecutive cycles, TX_DST_RDY=1 -> 1 cycle after 0x44: TX_SRC_RDY=1, TX_VLD=4'b1111, TX_DATA=0x44332211.
- Flush with same-cycle item: items 0xA1,0xA2, then 0xA3 together with FLUSH=1 -> TX_VLD=4'b0111, TX_DATA=0x00A3A2A1. FLUSH with cnt=0 and no item -> TX_SRC_RDY stays 0.
- Backpressure: full word with TX_DST_RDY=0 for 5 cycles -> TX_DATA/TX_VLD stable, RX_DST_RDY=0. On TX_DST_RDY=1 with input 0x55: word sent, next word holds 0x55 in lane 0, no items lost or duplicated.
- Streaming: 40 random items, TX_DST_RDY=1 -> 10 full words in order, one item accepted every cycle.
- Reset mid-word: 2 items accepted, RESET=1 for 1 cycle -> TX_SRC_RDY=0 and TX_VLD=0. The next 4 items form a clean word with no stale data.
- Timeout (macro set): single item 0x7E then idle -> TX_SRC_RDY=1 on the cycle TIMEOUT+1 after acceptance, TX_VLD=4'b0001, TX_DATA=0x0000007E. Without the macro, TX_SRC_RDY stays 0 for 100 idle cycles.

Source files
------------

// File: rtl/mvb_item_packer_if.sv
// mvb_item_packer_if: single-item RX stream, flush request and MVB TX bus of the item packer
interface mvb_item_packer_if #(
   parameter int ITEMS      = 4,
   parameter int ITEM_WIDTH = 8
);
   logic [ITEM_WIDTH-1:0]       RX_DATA;
   logic                        RX_SRC_RDY;
   logic                        RX_DST_RDY;
   logic                        FLUSH;
   logic [ITEMS*ITEM_WIDTH-1:0] TX_DATA;
   logic [ITEMS-1:0]            TX_VLD;
   logic                        TX_SRC_RDY;
   logic                        TX_DST_RDY;
   modport master (
      input  RX_DATA, RX_SRC_RDY, FLUSH, TX_DST_RDY,
      output RX_DST_RDY, TX_DATA, TX_VLD, TX_SRC_RDY
   );
   modport slave (
      output RX_DATA, RX_SRC_RDY, FLUSH, TX_DST_RDY,
      input  RX_DST_RDY, TX_DATA, TX_VLD, TX_SRC_RDY
   );
endinterface

// File: rtl/mvb_item_packer.sv
// mvb_item_packer: packs single items into ITEMS-lane MVB words; idle timeout enabled by MVB_ITEM_PACKER_TIMEOUT_EN
module mvb_item_packer #(
   parameter int ITEMS      = 4,
   parameter int ITEM_WIDTH = 8,
   parameter int TIMEOUT    = 16
) (
   input logic              CLK,
   input logic              RESET,
   mvb_item_packer_if.master bus
);
   localparam int CW = $clog2(ITEMS + 1);
   typedef enum logic {FILL, SEND} state_t;
   state_t                             state_q, state_d;
   logic [CW-1:0]                      cnt_q, cnt_d, cnt_acc;
   logic [ITEMS-1:0][ITEM_WIDTH-1:0]   lanes_q, lanes_d;
   logic [ITEMS-1:0]                   vld;
   logic                               rx_rdy, acc, tmo;
   if (ITEMS < 1 || ITEM_WIDTH < 1 || TIMEOUT < 1) begin : g_bad_param
      $error("mvb_item_packer: ITEMS, ITEM_WIDTH and TIMEOUT must be >= 1");
   end
   assign rx_rdy = !RESET && (state_q == FILL || bus.TX_DST_RDY);
   assign acc    = bus.RX_SRC_RDY && rx_rdy;
`ifdef MVB_ITEM_PACKER_TIMEOUT_EN
   localparam int IW = $clog2(TIMEOUT + 1);
   logic [IW-1:0] idle_q, idle_d;
   logic          idling;
   always_comb begin
      idling = state_q == FILL && cnt_q != '0 && !acc;
      idle_d = idling ? idle_q + 1'b1 : '0;
      tmo    = idling && idle_q == IW'(TIMEOUT - 1);
   end
   always_ff @(posedge CLK) idle_q <= RESET ? '0 : idle_d;
`else
   assign tmo = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lanes_d = lanes_q;
      cnt_acc = cnt_q + CW'(acc);
      if (state_q == FILL) begin
         for (int i = 0; i < ITEMS; i++) if (acc && cnt_q == CW'(i)) lanes_d[i] = bus.RX_DATA;
         cnt_d   = cnt_acc;
         state_d = (cnt_acc == CW'(ITEMS) || (bus.FLUSH && cnt_acc != '0) || tmo) ? SEND : FILL;
      end else if (bus.TX_DST_RDY) begin
         // a word just left: the same-cycle item opens the next word in lane 0, FLUSH is ignored
         lanes_d    = '0;
         lanes_d[0] = acc ? bus.RX_DATA : '0;
         cnt_d      = CW'(acc);
         state_d    = (acc && ITEMS == 1) ? SEND : FILL;
      end
   end
   always_comb begin
      vld = '0;
      for (int i = 0; i < ITEMS; i++) vld[i] = state_q == SEND && cnt_q > CW'(i);
   end
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= FILL;
         cnt_q   <= '0;
         lanes_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lanes_q <= lanes_d;
      end
   end
   assign bus.RX_DST_RDY = rx_rdy;
   assign bus.TX_SRC_RDY = state_q == SEND;
   assign bus.TX_DATA    = lanes_q;
   assign bus.TX_VLD     = vld;
endmodule

// File: tb/tb_mvb_item_packer.sv
// tb_mvb_item_packer: vector table plus scoreboarded sequences for mvb_item_packer
module tb_mvb_item_packer;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int TO = 16;
   typedef struct packed {
      logic [N*W-1:0] d;
      logic [N-1:0]   v;
   } word_t;
   typedef struct packed {
      logic [W-1:0]   d;
      logic           s, f, dr;
      logic           e_rdy, e_txs;
      logic [N-1:0]   e_v;
      logic [N*W-1:0] e_d;
   } vec_t;
   logic clk, rst;
   mvb_item_packer_if #(.ITEMS(N), .ITEM_WIDTH(W)) bus ();
   mvb_item_packer #(.ITEMS(N), .ITEM_WIDTH(W), .TIMEOUT(TO)) dut (.CLK(clk), .RESET(rst), .bus(bus));
   word_t          exp_q[$];
   vec_t           vt[$];
   logic [N*W-1:0] part;
   int             k, tests, fails, words_seen;
   logic           hold;
   logic [N*W-1:0] hold_d;
   logic [N-1:0]   hold_v;
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   function automatic vec_t mk(input logic [W-1:0] d, input logic s, input logic f, input logic dr,
                               input logic e_rdy, input logic e_txs, input logic [N-1:0] e_v, input logic [N*W-1:0] e_d);
      return '{d: d, s: s, f: f, dr: dr, e_rdy: e_rdy, e_txs: e_txs, e_v: e_v, e_d: e_d};
   endfunction
   task automatic drive(input logic r, input logic [W-1:0] d, input logic s, input logic f, input logic dr);
      rst = r;
      bus.RX_DATA = d;
      bus.RX_SRC_RDY = s;
      bus.FLUSH = f;
      bus.TX_DST_RDY = dr;
      #1;
   endtask
   // protocol checks and scoreboard update for the cycle driven by the last drive(), then advance
   task automatic finish_cycle();
      logic       acc, txx;
      logic [N-1:0] v;
      word_t      w;
      check("rx_dst_rdy", bus.RX_DST_RDY, !rst && (!bus.TX_SRC_RDY || bus.TX_DST_RDY));
      if (bus.TX_SRC_RDY) begin
         v = bus.TX_VLD;
         check("tx_vld_shape", v != '0 && (N'(v + 1'b1) & v) == '0, 1);
      end
      if (hold) check("tx_hold", {bus.TX_SRC_RDY, bus.TX_VLD, bus.TX_DATA}, {1'b1, hold_v, hold_d});
      acc = bus.RX_SRC_RDY && bus.RX_DST_RDY;
      txx = bus.TX_SRC_RDY && bus.TX_DST_RDY;
      hold = !rst && bus.TX_SRC_RDY && !txx;
      hold_d = bus.TX_DATA;
      hold_v = bus.TX_VLD;
      if (rst) begin
         exp_q.delete();
         k = 0;
         part = '0;
      end else begin
         if (txx) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL tx_word: got unexpected word %h vld %b, expected none", bus.TX_DATA, bus.TX_VLD);
            end else begin
               w = exp_q.pop_front();
               check("tx_data", bus.TX_DATA, w.d);
               check("tx_vld", bus.TX_VLD, w.v);
               words_seen++;
            end
         end
         if (acc) begin
            part[k*W +: W] = bus.RX_DATA;
            k++;
         end
         if (k == N || (bus.FLUSH && !bus.TX_SRC_RDY && k > 0)) begin
            exp_q.push_back('{d: part, v: N'((1 << k) - 1)});
            k = 0;
            part = '0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic cyc(input logic r, input logic [W-1:0] d, input logic s, input logic f, input logic dr);
      drive(r, d, s, f, dr);
      finish_cycle();
   endtask
   initial begin
      int ws, sends, first;
      tests = 0; fails = 0; words_seen = 0; k = 0; part = '0; hold = 1'b0;
      drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
      // full word, flush with same-cycle item, empty flush, backpressure with accept on release
      vt.push_back(mk(8'h11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0));
      vt.push_back(mk(8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0));
      vt.push_back(mk(8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0));
      vt.push_back(mk(8'h44, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0));
      vt.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h44332211));
      vt.push_back(mk(8'hA1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0));
      vt.push_back(mk(8'hA2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0));
      vt.push_back(mk(8'hA3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0));
      vt.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h7, 32'h00A3A2A1));
      vt.push_back(mk(8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0));
      vt.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0));
      vt.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0));
      vt.push_back(mk(8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0));
      vt.push_back(mk(8'h02, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0));
      vt.push_back(mk(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0));
      vt.push_back(mk(8'h04, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0));
      for (int i = 0; i < 5; i++) vt.push_back(mk(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 32'h04030201));
      vt.push_back(mk(8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h04030201));
      vt.push_back(mk(8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0));
      vt.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 32'h00000055));
      vt.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0));
      @(negedge clk);
      cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("reset_tx_src_rdy", bus.TX_SRC_RDY, 0);
      check("reset_tx_vld", bus.TX_VLD, 0);
      check("reset_tx_data", bus.TX_DATA, 0);
      finish_cycle();
      foreach (vt[i]) begin
         drive(1'b0, vt[i].d, vt[i].s, vt[i].f, vt[i].dr);
         check($sformatf("vec%0d_rx_dst_rdy", i), bus.RX_DST_RDY, vt[i].e_rdy);
         check($sformatf("vec%0d_tx_src_rdy", i), bus.TX_SRC_RDY, vt[i].e_txs);
         if (vt[i].e_txs) begin
            check($sformatf("vec%0d_tx_vld", i), bus.TX_VLD, vt[i].e_v);
            check($sformatf("vec%0d_tx_data", i), bus.TX_DATA, vt[i].e_d);
         end
         finish_cycle();
      end
      check("table_words", words_seen, 4);
      // streaming: 40 items back to back, one accepted every cycle
      ws = words_seen;
      for (int i = 0; i < 40; i++) cyc(1'b0, W'($urandom), 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("stream_words", words_seen - ws, 10);
      check("stream_queue_empty", exp_q.size(), 0);
      // reset mid-word discards the partial word
      cyc(1'b0, 8'hB1, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 8'hB2, 1'b1, 1'b0, 1'b1);
      cyc(1'b1, 8'hB3, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("midreset_tx_src_rdy", bus.TX_SRC_RDY, 0);
      check("midreset_tx_vld", bus.TX_VLD, 0);
      finish_cycle();
      ws = words_seen;
      cyc(1'b0, 8'hC1, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 8'hC2, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 8'hC3, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 8'hC4, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("postreset_data", bus.TX_DATA, 32'hC4C3C2C1);
      finish_cycle();
      check("postreset_words", words_seen - ws, 1);
      // lone item followed by idle cycles
      cyc(1'b0, 8'h7E, 1'b1, 1'b0, 1'b1);
`ifdef MVB_ITEM_PACKER_TIMEOUT_EN
      exp_q.push_back('{d: 32'h0000007E, v: 4'b0001});
      k = 0;
      part = '0;
      first = 0;
      for (int j = 1; j <= TO + 4; j++) begin
         drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
         if (bus.TX_SRC_RDY && first == 0) first = j;
         finish_cycle();
      end
      check("timeout_cycle", first, TO + 1);
`else
      sends = 0;
      for (int j = 0; j < 100; j++) begin
         drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
         if (bus.TX_SRC_RDY) sends++;
         finish_cycle();
      end
      check("no_timeout_send", sends, 0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
`endif
      check("final_queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
